// File: rtl/nonce_reporter.sv
// nonce_reporter: completes the core's claim/response handshake and buffers golden nonces for the host
// Ports: clk, n_rst (sync active-low); sol_claim/golden_nonce in, sol_response out (01 ACK, 10 REJ, 11 DUP);
//        job_clear flushes; rd_req pops, rd_valid/rd_data show the FIFO head; count = entries held;
//        overflow is sticky on any reject. Define NONCE_DEDUP_EN to reject repeats of the last accepted nonce.
module nonce_reporter #(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          sol_claim,
    input  logic [31:0]   golden_nonce,
    output logic [1:0]    sol_response,
    input  logic          job_clear,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    output logic [CW-1:0] count,
    output logic          overflow
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, RESP, WAITLOW} state_t;
    state_t state;
    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic full, dup, push, pop;
    assign full = count == CW'(DEPTH);
`ifdef NONCE_DEDUP_EN
    logic [31:0] last_nonce;
    logic last_vld;
    assign dup = last_vld && golden_nonce == last_nonce;
    always_ff @(posedge clk) begin
        if (!n_rst || job_clear) begin
            last_nonce <= '0;
            last_vld   <= 1'b0;
        end else if (push) begin
            last_nonce <= golden_nonce;
            last_vld   <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif
    assign push     = n_rst && !job_clear && state == IDLE && sol_claim && !dup && !full;
    assign pop      = n_rst && !job_clear && rd_req && rd_valid;
    assign rd_valid = count != '0;
    assign rd_data  = rd_valid ? mem[rptr] : '0;
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= golden_nonce;
    end
    always_ff @(posedge clk) begin
        if (!n_rst || job_clear) begin
            state        <= IDLE;
            sol_response <= 2'b00;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            overflow     <= 1'b0;
        end else begin
            wptr  <= push ? wptr + 1'b1 : wptr;
            rptr  <= pop ? rptr + 1'b1 : rptr;
            count <= count + CW'(push) - CW'(pop);
            case (state)
                IDLE: if (sol_claim) begin
                    state        <= RESP;
                    sol_response <= dup ? 2'b11 : full ? 2'b10 : 2'b01;
                    overflow     <= overflow || (!dup && full);
                end
                RESP: begin
                    state        <= WAITLOW;
                    sol_response <= 2'b00;
                end
                WAITLOW: state <= sol_claim ? WAITLOW : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nonce_reporter.sv
// tb_nonce_reporter: directed self-checking bench for nonce_reporter (DEPTH=4)
module tb_nonce_reporter;
    logic        clk = 1'b0;
    logic        n_rst, sol_claim, job_clear, rd_req;
    logic [31:0] golden_nonce, rd_data;
    logic [1:0]  sol_response, r;
    logic        rd_valid, overflow;
    logic [2:0]  count;
    int vectors = 0;
    int errs = 0;
    int acks;

    nonce_reporter dut (
        .clk(clk), .n_rst(n_rst), .sol_claim(sol_claim), .golden_nonce(golden_nonce),
        .sol_response(sol_response), .job_clear(job_clear), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Decision edge, RESP edge, WAITLOW edge with claim low: leaves the FSM back in IDLE.
    task automatic do_claim(input logic [31:0] n, output logic [1:0] code);
        sol_claim = 1'b1;
        golden_nonce = n;
        step;
        code = sol_response;
        sol_claim = 1'b0;
        step;
        step;
    endtask

    initial begin
        n_rst = 1'b0; sol_claim = 1'b0; job_clear = 1'b0; rd_req = 1'b0; golden_nonce = '0;
        step;
        step;
        chk("rst_resp", 32'(sol_response), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data", rd_data, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        n_rst = 1'b1;
        step;

        sol_claim = 1'b1; golden_nonce = 32'hDEADBEEF;
        step;
        chk("mid_resp_code", 32'(sol_response), 1);
        chk("mid_resp_count", 32'(count), 1);
        n_rst = 1'b0; sol_claim = 1'b0;
        step;
        chk("midrst_resp", 32'(sol_response), 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_valid", 32'(rd_valid), 0);
        chk("midrst_data", rd_data, 0);
        n_rst = 1'b1;
        step;

        sol_claim = 1'b1; golden_nonce = 32'h12345678; acks = 0;
        step;
        chk("single_resp", 32'(sol_response), 1);
        chk("single_count", 32'(count), 1);
        chk("single_data", rd_data, 32'h12345678);
        chk("single_valid", 32'(rd_valid), 1);
        for (int i = 0; i < 4; i++) begin
            step;
            if (sol_response == 2'b01) acks++;
        end
        chk("single_extra_acks", 32'(acks), 0);
        sol_claim = 1'b0;
        step;
        rd_req = 1'b1;
        step;
        rd_req = 1'b0;
        chk("pop_valid", 32'(rd_valid), 0);
        chk("pop_data", rd_data, 0);
        chk("pop_count", 32'(count), 0);
        rd_req = 1'b1;
        step;
        rd_req = 1'b0;
        chk("underflow_count", 32'(count), 0);

        for (int i = 1; i <= 5; i++) begin
            do_claim(32'(i), r);
            chk($sformatf("fill_code%0d", i), 32'(r), i < 5 ? 1 : 2);
        end
        chk("fill_ovf", 32'(overflow), 1);
        chk("fill_count", 32'(count), 4);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain%0d", i), rd_data, 32'(i));
            rd_req = 1'b1;
            step;
        end
        rd_req = 1'b0;
        chk("drain_count", 32'(count), 0);
        chk("drain_data", rd_data, 0);

        for (int i = 10; i <= 13; i++) begin
            do_claim(32'(i), r);
            chk($sformatf("refill_code%0d", i), 32'(r), 1);
        end
        sol_claim = 1'b1; golden_nonce = 32'd14; rd_req = 1'b1;
        step;
        sol_claim = 1'b0; rd_req = 1'b0;
        chk("full_pop_code", 32'(sol_response), 2);
        chk("full_pop_count", 32'(count), 3);
        chk("full_pop_ovf", 32'(overflow), 1);
        step;
        step;
        do_claim(32'd15, r);
        chk("after_pop_code", 32'(r), 1);
        chk("after_pop_count", 32'(count), 4);
        chk("after_pop_head", rd_data, 32'd11);

        rd_req = 1'b1;
        step;
        rd_req = 1'b0;
        chk("pre_clear_count", 32'(count), 3);
        job_clear = 1'b1; sol_claim = 1'b1; golden_nonce = 32'd99;
        step;
        job_clear = 1'b0; sol_claim = 1'b0;
        chk("clear_count", 32'(count), 0);
        chk("clear_ovf", 32'(overflow), 0);
        chk("clear_resp", 32'(sol_response), 0);
        chk("clear_valid", 32'(rd_valid), 0);
        step;
        chk("clear_claim_ignored", 32'(count), 0);

        sol_claim = 1'b1; golden_nonce = 32'd77; acks = 0;
        for (int i = 0; i < 10; i++) begin
            step;
            if (sol_response == 2'b01) acks++;
        end
        sol_claim = 1'b0;
        step;
        chk("held_acks", 32'(acks), 1);
        chk("held_count", 32'(count), 1);
        chk("held_data", rd_data, 32'd77);

        job_clear = 1'b1;
        step;
        job_clear = 1'b0;
        do_claim(32'hA5A5A5A5, r);
        chk("dup_first", 32'(r), 1);
        do_claim(32'hA5A5A5A5, r);
`ifdef NONCE_DEDUP_EN
        chk("dup_second", 32'(r), 3);
`else
        chk("dup_second", 32'(r), 1);
`endif
        do_claim(32'h00000001, r);
        chk("dup_third", 32'(r), 1);
`ifdef NONCE_DEDUP_EN
        chk("dup_count", 32'(count), 2);
`else
        chk("dup_count", 32'(count), 3);
`endif
        chk("dup_ovf", 32'(overflow), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/nonce_reporter.md
# nonce_reporter

Solution-side stage downstream of the SHA mining core. Completes the core's `sol_claim`/`sol_response` handshake, captures each golden nonce into a small show-ahead FIFO, and presents buffered nonces to the host read interface. A new job (`job_clear`) flushes everything.

## Interface

**Parameters**
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥2.
- `CW`, default `$clog2(DEPTH)+1`: width of `count`. Derived; do not override.

**Ports**
- `clk` in 1: single clock; all logic on the rising edge.
- `n_rst` in 1: synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `sol_claim` in 1: core asserts this with a valid nonce and holds it until it sees a non-zero `sol_response`.
- `golden_nonce` in 32: nonce from the core. Valid while `sol_claim` = 1.
- `sol_response` out 2: 00 = none, 01 = ACK (stored), 10 = REJ (FIFO full), 11 = DUP (only with the macro).
- `job_clear` in 1: flush for a new job. Driven from the core's `start_found`.
- `rd_req` in 1: host pop request.
- `rd_valid` out 1: FIFO non-empty.
- `rd_data` out 32: FIFO head; 0 when empty.
- `count` out CW: number of entries held, 0..DEPTH.
- `overflow` out 1: sticky; set on any REJ.

## Operation

**Reset and flush**
- Reset (`n_rst` = 0 at an edge): `sol_response`=00, `rd_valid`=0, `rd_data`=0, `count`=0, `overflow`=0, pointers=0, FSM=IDLE.
- `job_clear` = 1 at an edge does the same, except memory contents are left as-is.
- `job_clear` has priority over claims and reads in the same cycle.
- Reset or `job_clear` in any FSM state returns the FSM to IDLE.

**FSM states**
- IDLE: `sol_response`=00. If `sol_claim`=1 at an edge, decide the claim, go to RESP, and register the response code.
  - Not full → push `golden_nonce`, code 01.
  - Full → no push, code 10, set `overflow`.
- RESP: `sol_response` holds the code for exactly one cycle, then the FSM goes to WAITLOW.
- WAITLOW: `sol_response`=00. Stay until `sol_claim` is sampled 0, then go to IDLE.
  - A claim held high is therefore accepted only once.
  - The earliest next claim is accepted 3 cycles after the previous decision.

**FIFO**
- Show-ahead: `rd_data` = mem[rptr] when `count` ≠ 0.
- Pop: `rd_req` && `rd_valid` at an edge increments `rptr`.
- `rd_req` while empty is ignored; no underflow.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Full/accept decisions use `count` as it was before the edge. A push with `count`=DEPTH is rejected even if a pop happens in the same cycle.
- Push and pop in the same cycle with `count` < DEPTH: `count` is unchanged, and both pointers advance.
- `overflow` is cleared only by reset or `job_clear`.

## Timing

- Claim sampled high at edge N:
  - `sol_response` is valid during cycle N+1 (after edge N) and returns to 00 after edge N+1.
  - On ACK, `rd_valid`/`count` update after edge N, so the nonce is readable in cycle N+1.
- Pop at edge M: the next entry (or 0 if empty) appears on `rd_data` after edge M.
- Host throughput: one pop per cycle.
- Claim throughput: one decision per 3 cycles minimum.
- All outputs are registered or derived from registered state only; there are no combinational input-to-output paths.

## Configuration

- `NONCE_DEDUP_EN` defined:
  - The block keeps `last_nonce` (32 bits) and `last_vld`, both cleared by reset and `job_clear`.
  - A claim whose `golden_nonce` equals `last_nonce` while `last_vld`=1 is not pushed and gets code 11.
  - A DUP does not set `overflow` and does not update `last_nonce`. The DUP check comes before the full check.
  - Each ACK loads `last_nonce` and sets `last_vld`.
- `NONCE_DEDUP_EN` undefined: no such registers exist, code 11 is never driven, and duplicates are treated like any other claim.

## Test plan

- Reset mid-RESP: claim 0xDEADBEEF, assert `n_rst`=0 on the next edge → all outputs 0, FSM IDLE, `rd_valid`=0.
- Single claim 0x12345678 held 5 cycles → exactly one cycle of `sol_response`=01, `count`=1, `rd_data`=0x12345678 one cycle after the decision. Pop → `rd_valid`=0, `rd_data`=0.
- DEPTH=4: claims 1,2,3,4,5, no reads →
  - first four get 01, the fifth gets 10, `overflow`=1, `count`=4;
  - then four pops return 1,2,3,4 in order.
- Full FIFO, with claim decision and `rd_req` at the same edge → 10 (reject), `count`=3, `overflow`=1. Next claim → 01, `count`=4.
- Held-claim and flush cases:
  - `sol_claim` held high continuously for 10 cycles → only one push.
  - `job_clear` while `count`=3 and `overflow`=1 → `count`=0, `overflow`=0.
  - A claim in the same cycle as `job_clear` is ignored.
- With `NONCE_DEDUP_EN` defined: claims 0xA5A5A5A5, 0xA5A5A5A5, 0x00000001 → responses 01, 11, 01, and `count`=2.
